mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the pipelined MIPS core, sitting in the execute stage directly downstream of the general register file. It consumes the two register read values (rs, rt), runs mult/multu/div/divu as a multi-cycle operation, and holds the HI/LO registers. The mfhi/mflo path carries HI/LO onward through the pipeline to the register-file write port. The hazard unit stalls decode on the `busy` output.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` is high for mult/multu.
- `DIV_CYCLES`, default 10: cycles `busy` is high for div/divu.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately on assertion.
- `op` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7–15 are treated as none.
- `cancel` input 1: suppresses the `op` presented in the same cycle (used for exception/interrupt flush).
- `a` input 32: rs value (dividend or multiplicand; source for mthi/mtlo).
- `b` input 32: rt value (divisor or multiplier).
- `busy` output 1: registered; high while an operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- Accept condition: `op` ∈ {1..6}, `cancel`=0, and `busy`=0.
  - Ops presented while `busy`=1 are ignored; the hazard unit guarantees this does not occur.
- mult/multu/div/divu on accept:
  - Compute the result from `a`/`b` and store it in internal pending registers.
  - Load the counter with N (MULT_CYCLES or DIV_CYCLES) and set `busy`.
- States:
  - IDLE to RUN on accept of ops 1–4.
  - RUN: decrement the counter each cycle.
  - When the counter equals 1, write the pending HI/LO into `hi`/`lo`, clear `busy`, and return to IDLE.
- mthi/mtlo on accept: write `a` into `hi`/`lo` at that edge; `busy` stays 0.
- Arithmetic:
  - mult: signed 32×32 to 64; `hi` = upper 32 bits, `lo` = lower 32 bits.
  - multu: same as mult, unsigned.
  - div: signed; `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero: normal busy timing, but commit is suppressed; `hi`/`lo` are unchanged.
- `cancel` has no effect on an operation already in RUN; in-flight operations always complete.
- Reset mid-operation: the operation is aborted and its pending result is discarded.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0; counter and pending registers are 0.
- For an op accepted at the edge ending cycle T:
  - `busy`=1 in cycles T+1..T+N.
  - `hi`/`lo` take their new values at the edge ending T+N and are visible in T+N+1, the same cycle `busy` falls.
- Back-to-back: a new op may be accepted in cycle T+N+1.
- mthi/mtlo accepted in cycle T are visible in T+1.
- `hi`/`lo` hold their old values throughout RUN.
- The hazard unit must stall on (`op` ∈ 1..4 in E) or `busy`, since `busy` lags accept by one cycle.

## Configuration
- `MDU_DIV_EN` defined:
  - div/divu are implemented as above.
- `MDU_DIV_EN` undefined:
  - ops 3/4 are treated as none: not accepted, `busy` stays 0, `hi`/`lo` unchanged.
  - No divider logic is synthesized; `DIV_CYCLES` is unused.

## Test plan
- mult a=0xFFFFFFFF, b=2 → `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 busy cycles.
- div a=0xFFFFFFF9 (−7), b=2 → `busy` high 10 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Also div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- divu a=7, b=0 with `hi`=0x11, `lo`=0x22 beforehand → `busy` high 10 cycles, then `hi`=0x11, `lo`=0x22.
  - With `MDU_DIV_EN` undefined: `busy` never rises.
- mthi a=0x12345678 → `hi`=0x12345678 next cycle, `busy`=0.
  - mtlo with `cancel`=1 → `lo` unchanged.
  - mult presented during RUN → ignored.
- mult a=3, b=4, then `reset` driven low in the 3rd busy cycle → `busy`=0, `hi`=`lo`=0 immediately (before next edge); after release, no commit occurs.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the MIPS HI/LO registers.
// Optional divider enabled by defining MDU_DIV_EN; otherwise div/divu behave as no-ops.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      pend_hi, pend_hi_nxt;
    logic [31:0]      pend_lo, pend_lo_nxt;
    logic             pend_we, pend_we_nxt;
    logic [31:0]      hi_nxt, lo_nxt;
    logic             busy_nxt;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_DIVU = 4'd4;

    logic        div_ovf;
    logic [31:0] b_div;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    // A divisor of 1 covers both the zero case (no commit) and the signed overflow case,
    // where a / 1 already yields quotient 0x80000000 and remainder 0.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign b_div   = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
    assign quot_s  = 32'($signed(a) / $signed(b_div));
    assign rem_s   = 32'($signed(a) % $signed(b_div));
    assign quot_u  = a / b_div;
    assign rem_u   = a % b_div;
`endif

    // Next-state, pending result and HI/LO update logic
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_we_nxt = pend_we;
        hi_nxt      = hi;
        lo_nxt      = lo;

        case (state)
            IDLE: begin
                if (!cancel) begin
                    case (op)
                        OP_MULT: begin
                            pend_hi_nxt = prod_s[63:32];
                            pend_lo_nxt = prod_s[31:0];
                            pend_we_nxt = 1'b1;
                            cnt_nxt     = MULT_N;
                            state_nxt   = RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_nxt = prod_u[63:32];
                            pend_lo_nxt = prod_u[31:0];
                            pend_we_nxt = 1'b1;
                            cnt_nxt     = MULT_N;
                            state_nxt   = RUN;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV: begin
                            pend_hi_nxt = rem_s;
                            pend_lo_nxt = quot_s;
                            pend_we_nxt = (b != 32'd0);
                            cnt_nxt     = DIV_N;
                            state_nxt   = RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_nxt = rem_u;
                            pend_lo_nxt = quot_u;
                            pend_we_nxt = (b != 32'd0);
                            cnt_nxt     = DIV_N;
                            state_nxt   = RUN;
                        end
`endif
                        OP_MTHI: hi_nxt = a;
                        OP_MTLO: lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    if (pend_we) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_we <= pend_we_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the driver queues expected busy/HI/LO per cycle from an
// arithmetic reference model; a negedge monitor pops and compares.
module tb_mdu;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        cancel;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .op(op), .cancel(cancel),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic bz, input logic [31:0] h, input logic [31:0] l,
                             input string nm);
        exp_t e;
        e.cyc = c; e.busy = bz; e.hi = h; e.lo = l; e.name = nm;
        q.push_back(e);
    endtask

    // Reference arithmetic on 64-bit integers
    function automatic void model(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                  output bit lng, output bit we, output logic [31:0] rh,
                                  output logic [31:0] rl);
        longint          sa, sb, p, r;
        longint unsigned ua, ub;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        ua = longint'(xa);
        ub = longint'(xb);
        lng = 1'b0; we = 1'b0; rh = 32'd0; rl = 32'd0;
        p = 0; r = 0;
        case (o)
            4'd1: begin lng = 1'b1; we = 1'b1; p = sa * sb; end
            4'd2: begin lng = 1'b1; we = 1'b1; p = longint'(ua * ub); end
            4'd3: if (DIV_EN) begin
                lng = 1'b1; we = (xb != 32'd0);
                if (we) begin p = sa / sb; r = sa % sb; end
            end
            4'd4: if (DIV_EN) begin
                lng = 1'b1; we = (xb != 32'd0);
                if (we) begin p = longint'(ua / ub); r = longint'(ua % ub); end
            end
            default: ;
        endcase
        if (o == 4'd1 || o == 4'd2) begin
            rh = p[63:32]; rl = p[31:0];
        end else begin
            rh = r[31:0]; rl = p[31:0];
        end
    endfunction

    // Present one op at the current negedge and wait until the unit is free again
    task automatic run_op(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input logic c, input bit junk, input string nm);
        bit          lng, we;
        logic [31:0] rh, rl;
        int          t, n;
        model(o, xa, xb, lng, we, rh, rl);
        t = cyc;
        n = 0;
        op = o; a = xa; b = xb; cancel = c;
        if (!c && lng) begin
            n = (o <= 4'd2) ? int'(MC) : int'(DC);
            expect_at(t + 1, 1'b1, m_hi, m_lo, {nm, " busy start"});
            expect_at(t + n, 1'b1, m_hi, m_lo, {nm, " busy end"});
            if (we) begin m_hi = rh; m_lo = rl; end
            expect_at(t + n + 1, 1'b0, m_hi, m_lo, {nm, " commit"});
        end else begin
            if (!c && o == 4'd5) m_hi = xa;
            if (!c && o == 4'd6) m_lo = xa;
            expect_at(t + 1, 1'b0, m_hi, m_lo, nm);
        end
        @(negedge clk);
        op = 4'd0; cancel = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (junk) begin
                op = 4'($urandom_range(1, 6));
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            op = 4'd0;
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || busy !== e.busy || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL %s cyc=%0d(want %0d) got busy=%b hi=%h lo=%h want busy=%b hi=%h lo=%h",
                         e.name, cyc, e.cyc, busy, hi, lo, e.busy, e.hi, e.lo);
            end
        end
    end

    initial begin
        int          t;
        logic [3:0]  o;
        logic [31:0] xa, xb;
        logic        c;

        reset = 1'b0; op = 4'd0; cancel = 1'b0; a = 32'd0; b = 32'd0;
        @(negedge clk);
        expect_at(cyc + 1, 1'b0, 32'd0, 32'd0, "reset values");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, "mult -1*2");
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, "multu ffffffff*2");
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div -7/2");
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div overflow");
        run_op(4'd5, 32'h11, 32'd0, 1'b0, 1'b0, "mthi 11");
        run_op(4'd6, 32'h22, 32'd0, 1'b0, 1'b0, "mtlo 22");
        run_op(4'd4, 32'd7, 32'd0, 1'b0, 1'b0, "divu by zero");
        run_op(4'd3, 32'd100, 32'd0, 1'b0, 1'b0, "div by zero");
        run_op(4'd4, 32'hFFFF_FFF0, 32'd7, 1'b0, 1'b0, "divu big");
        run_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "mthi 12345678");
        run_op(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, "mtlo cancelled");
        run_op(4'd1, 32'h0001_0003, 32'hFFFF_0005, 1'b0, 1'b1, "mult with ops during run");
        run_op(4'd1, 32'd9, 32'd9, 1'b1, 1'b0, "mult cancelled");
        run_op(4'd9, 32'hAAAA_AAAA, 32'd1, 1'b0, 1'b0, "op 9 ignored");
        run_op(4'd15, 32'hBBBB_BBBB, 32'd1, 1'b0, 1'b0, "op 15 ignored");

        for (int i = 0; i < 40; i++) begin
            o  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
            xa = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: xb = 32'd0;
                1: xb = 32'hFFFF_FFFF;
                2: xb = 32'($urandom_range(1, 20));
                default: xb = $urandom;
            endcase
            c = ($urandom_range(0, 7) == 0);
            run_op(o, xa, xb, c, bit'($urandom_range(0, 1)), "random op");
        end

        run_op(4'd5, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0, "mthi before reset");
        run_op(4'd6, 32'h5A5A_5A5A, 32'd0, 1'b0, 1'b0, "mtlo before reset");
        t = cyc;
        op = 4'd1; a = 32'd3; b = 32'd4; cancel = 1'b0;
        expect_at(t + 1, 1'b1, m_hi, m_lo, "reset-test mult busy");
        @(negedge clk);
        op = 4'd0;
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        expect_at(t + 3, 1'b0, 32'd0, 32'd0, "async reset mid-run");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 4; i <= 10; i++) expect_at(t + i, 1'b0, 32'd0, 32'd0, "no commit after reset");
        repeat (8) @(negedge clk);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
